// File: rtl/ex_wb_stage.sv
// EX/WB pipeline register and writeback stage for the 8-bit shift/move pipeline.
// Drives the register-file write port, EX forwarding selects and a retired-write counter.
module ex_wb_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] ALU_out,
  input  logic [DATA_W-1:0] EX_WB_Rsdata_in,
  input  logic [ADDR_W-1:0] EX_WB_Rd_in,
  input  logic              EX_WB_write_mux_in,
  input  logic              EX_WB_regWrite_in,
  input  logic [ADDR_W-1:0] EX_ID_Rs_out,
  input  logic [ADDR_W-1:0] EX_ID_Rd_out,
  output logic [DATA_W-1:0] WB_mux_out,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [1:0]        ctrl,
  output logic [CNT_W-1:0]  retire_cnt
);

  logic              valid_q;
  logic              reg_write_q;
  logic              write_mux_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] rs_q;
  logic [CNT_W-1:0]  retire_cnt_q;
  logic              hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      write_mux_q  <= 1'b0;
      rd_q         <= '0;
      alu_q        <= '0;
      rs_q         <= '0;
      retire_cnt_q <= '0;
    end else begin
      // The WB instruction completes even when a bubble is flushed in behind it.
      if (rf_we && !stall)
        retire_cnt_q <= retire_cnt_q + CNT_W'(1);
      if (flush) begin
        valid_q     <= 1'b0;
        reg_write_q <= 1'b0;
        write_mux_q <= 1'b0;
        rd_q        <= '0;
        alu_q       <= '0;
        rs_q        <= '0;
      end else if (!stall) begin
        valid_q     <= 1'b1;
        reg_write_q <= EX_WB_regWrite_in;
        write_mux_q <= EX_WB_write_mux_in;
        rd_q        <= EX_WB_Rd_in;
        alu_q       <= ALU_out;
        rs_q        <= EX_WB_Rsdata_in;
      end
    end
  end

  assign hit        = valid_q & reg_write_q;
  assign WB_mux_out = write_mux_q ? alu_q : rs_q;
  assign rf_we      = hit;
  assign rf_waddr   = rd_q;
  assign rf_wdata   = WB_mux_out;
  assign ctrl       = {hit & (rd_q == EX_ID_Rd_out), hit & (rd_q == EX_ID_Rs_out)};
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage: expected writebacks are queued when stimulus is
// driven and moved to the WB model when the bench's capture rules say they retire.
module tb_ex_wb_stage;

  logic       clk = 1'b0;
  logic       reset, stall, flush;
  logic [7:0] alu_in, rsdata_in;
  logic [2:0] rd_in, ex_rs, ex_rd;
  logic       wmux_in, regw_in;
  logic [7:0] wb_mux_out, rf_wdata;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [1:0] ctrl;
  logic [15:0] retire_cnt;

  typedef struct packed {
    logic [7:0] data;
    logic       we;
    logic [2:0] waddr;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur;
  logic [15:0] exp_cnt;
  int          errors = 0;
  int          checks = 0;

  ex_wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ALU_out(alu_in), .EX_WB_Rsdata_in(rsdata_in), .EX_WB_Rd_in(rd_in),
    .EX_WB_write_mux_in(wmux_in), .EX_WB_regWrite_in(regw_in),
    .EX_ID_Rs_out(ex_rs), .EX_ID_Rd_out(ex_rd),
    .WB_mux_out(wb_mux_out), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .ctrl(ctrl), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    logic [1:0] exp_ctrl;
    exp_ctrl = {cur.we && (cur.waddr == ex_rd), cur.we && (cur.waddr == ex_rs)};
    chk({tag, "_wb"},    {24'b0, wb_mux_out}, {24'b0, cur.data});
    chk({tag, "_wdata"}, {24'b0, rf_wdata},   {24'b0, cur.data});
    chk({tag, "_we"},    {31'b0, rf_we},      {31'b0, cur.we});
    chk({tag, "_waddr"}, {29'b0, rf_waddr},   {29'b0, cur.waddr});
    chk({tag, "_ctrl"},  {30'b0, ctrl},       {30'b0, exp_ctrl});
    chk({tag, "_cnt"},   {16'b0, retire_cnt}, {16'b0, exp_cnt});
  endtask

  // A newer instruction in EX replaces any one that has not been captured yet.
  task automatic drive(input logic [7:0] alu, input logic [7:0] rs, input logic [2:0] rd,
                       input logic wm, input logic rw);
    exp_t e;
    alu_in = alu; rsdata_in = rs; rd_in = rd; wmux_in = wm; regw_in = rw;
    e.data = wm ? alu : rs;
    e.we = rw;
    e.waddr = wm ? rd : rd;
    sb_q.delete();
    sb_q.push_back(e);
  endtask

  task automatic tick();
    if (reset) begin
      sb_q.delete();
      cur = '0;
      exp_cnt = '0;
    end else begin
      if (cur.we && !stall) exp_cnt = exp_cnt + 16'd1;
      if (flush) begin
        cur = '0;
        sb_q.delete();
      end else if (!stall) begin
        if (sb_q.size() > 0) cur = sb_q.pop_front();
        else chk("sb_empty", 32'd0, 32'd1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    alu_in = '0; rsdata_in = '0; rd_in = '0; wmux_in = 1'b0; regw_in = 1'b0;
    ex_rs = 3'd7; ex_rd = 3'd7;
    cur = '0; exp_cnt = '0;
    tick(); tick();
    reset = 1'b0;
    check_all("reset");

    // Basic writeback selection and regWrite gating
    drive(8'h3C, 8'h11, 3'd5, 1'b1, 1'b1); tick(); check_all("alu_sel");
    chk("alu_sel_lit", {24'b0, wb_mux_out}, 32'h3C);
    drive(8'h3C, 8'h11, 3'd5, 1'b0, 1'b1); tick(); check_all("rs_sel");
    chk("first_retire", {16'b0, retire_cnt}, 32'd1);
    ex_rs = 3'd5; ex_rd = 3'd5;
    drive(8'h3C, 8'h11, 3'd5, 1'b1, 1'b0); tick(); check_all("no_regwrite");

    // Forwarding selects
    drive(8'h00, 8'h55, 3'd3, 1'b0, 1'b1); tick();
    ex_rs = 3'd3; ex_rd = 3'd3; #1; check_all("fwd_both");
    chk("fwd_both_lit", {30'b0, ctrl}, 32'd3);
    ex_rs = 3'd3; ex_rd = 3'd4; #1; check_all("fwd_rs");
    ex_rs = 3'd2; ex_rd = 3'd3; #1; check_all("fwd_rd");
    drive(8'h00, 8'h66, 3'd0, 1'b0, 1'b1); tick();
    ex_rs = 3'd0; ex_rd = 3'd1; #1; check_all("fwd_r0");

    // Stall holds WB contents and the counter while EX inputs change
    ex_rs = 3'd2; ex_rd = 3'd0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(8'($urandom_range(255)), 8'($urandom_range(255)), 3'(i + 4), 1'b1, 1'b1);
      tick();
      check_all($sformatf("stall%0d", i));
    end
    stall = 1'b0;
    drive(8'hC3, 8'h7E, 3'd6, 1'b1, 1'b1); tick(); check_all("stall_release");

    // Flush overrides stall; reset discards the in-flight write
    drive(8'hAA, 8'hBB, 3'd2, 1'b1, 1'b1); tick();
    flush = 1'b1; stall = 1'b1; tick(); check_all("flush_stall");
    flush = 1'b0; stall = 1'b0;
    drive(8'h5A, 8'hA5, 3'd7, 1'b0, 1'b1); tick(); check_all("pre_reset");
    reset = 1'b1; tick(); reset = 1'b0; check_all("mid_reset");
    chk("mid_reset_cnt", {16'b0, retire_cnt}, 32'd0);

    // Counter wrap
    drive(8'h42, 8'h00, 3'd1, 1'b1, 1'b1); tick();
    while (exp_cnt != 16'hFFFF) begin
      drive(8'h42, 8'h00, 3'd1, 1'b1, 1'b1);
      tick();
    end
    check_all("cnt_max");
    drive(8'h42, 8'h00, 3'd1, 1'b1, 1'b1); tick(); check_all("cnt_wrap");
    chk("cnt_wrap_lit", {16'b0, retire_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
